// File: rtl/panic_rx_mux.sv
// Packet-atomic N:1 AXI-Stream merge in front of the PANIC RX stream.
// Round-robin or fixed-priority arbitration, registered output, per-port packet stats.
module panic_rx_mux #(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8,
  parameter int PORTS           = 4,
  parameter int ARB_MODE        = 0,
  parameter int ID_WIDTH        = (PORTS > 1 ? $clog2(PORTS) : 1),
  parameter int CNT_WIDTH       = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [PORTS*AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [PORTS*AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [PORTS-1:0]             s_axis_tvalid,
  output logic [PORTS-1:0]             s_axis_tready,
  input  logic [PORTS-1:0]             s_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [ID_WIDTH-1:0]          m_axis_tid,
  output logic [PORTS*CNT_WIDTH-1:0]   stat_pkt_count
);

  // Handshake: a beat moves when valid and ready are both high at a rising edge;
  // valid never waits on ready, and data is held while valid is high and ready low.

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                       state_q;
  logic [ID_WIDTH-1:0]          grant_q;
  logic [ID_WIDTH-1:0]          rr_ptr_q;
  logic [ID_WIDTH-1:0]          rr_ptr_d;
  logic [ID_WIDTH-1:0]          arb_grant;
  logic [ID_WIDTH-1:0]          rr_idx;
  logic                         arb_found;
  logic                         any_req;
  logic                         out_ready;
  logic                         beat_acc;
  logic                         sel_last;

  logic [AXIS_DATA_WIDTH-1:0]   m_data_q;
  logic [AXIS_KEEP_WIDTH-1:0]   m_keep_q;
  logic                         m_valid_q;
  logic                         m_last_q;
  logic [ID_WIDTH-1:0]          m_id_q;
  logic [CNT_WIDTH-1:0]         cnt_q [PORTS];

  logic [AXIS_DATA_WIDTH-1:0]   in_data [PORTS];
  logic [AXIS_KEEP_WIDTH-1:0]   in_keep [PORTS];

  for (genvar g = 0; g < PORTS; g++) begin : g_port
    assign in_data[g] = s_axis_tdata[g*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
    assign in_keep[g] = s_axis_tkeep[g*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
    assign stat_pkt_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

  assign any_req   = |s_axis_tvalid;
  assign out_ready = !m_valid_q || m_axis_tready;
  assign beat_acc  = (state_q == BUSY) && s_axis_tvalid[grant_q] && out_ready;
  assign sel_last  = s_axis_tlast[grant_q];

  always_comb begin
    arb_grant = '0;
    arb_found = 1'b0;
    rr_idx    = '0;
    if (ARB_MODE == 1) begin
      for (int i = PORTS-1; i >= 0; i--) begin
        if (s_axis_tvalid[i]) arb_grant = ID_WIDTH'(i);
      end
    end else begin
      // Walk the ports starting at the pointer, wrapping modulo PORTS.
      for (int k = 0; k < PORTS; k++) begin
        rr_idx = ID_WIDTH'((int'(rr_ptr_q) + k) % PORTS);
        if (!arb_found && s_axis_tvalid[rr_idx]) begin
          arb_grant = rr_idx;
          arb_found = 1'b1;
        end
      end
    end
  end

  assign rr_ptr_d = (arb_grant == ID_WIDTH'(PORTS-1)) ? '0 : arb_grant + 1'b1;

  always_comb begin
    s_axis_tready = '0;
    if (state_q == BUSY) s_axis_tready[grant_q] = out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_id_q    <= '0;
      for (int i = 0; i < PORTS; i++) cnt_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q <= BUSY;
            grant_q <= arb_grant;
            if (ARB_MODE == 0) rr_ptr_q <= rr_ptr_d;
          end
        end
        BUSY: begin
          if (beat_acc && sel_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (beat_acc) begin
        m_data_q  <= in_data[grant_q];
        m_keep_q  <= in_keep[grant_q];
        m_last_q  <= sel_last;
        m_id_q    <= grant_q;
        m_valid_q <= 1'b1;
      end else if (m_axis_tready) begin
        m_valid_q <= 1'b0;
      end

      for (int i = 0; i < PORTS; i++) begin
        if (beat_acc && sel_last && (grant_q == ID_WIDTH'(i))) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tid    = m_id_q;

endmodule

// File: tb/tb_panic_rx_mux.sv
// Directed bench for panic_rx_mux: a round-robin instance (a_*) and a
// fixed-priority instance with 4-bit counters (b_*), checked cycle by cycle.
module tb_panic_rx_mux;

  localparam int DW = 16;
  localparam int KW = 2;
  localparam int P  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [P*DW-1:0] a_tdata, b_tdata;
  logic [P*KW-1:0] a_tkeep, b_tkeep;
  logic [P-1:0]    a_tvalid, a_tready, a_tlast;
  logic [P-1:0]    b_tvalid, b_tready, b_tlast;
  logic [DW-1:0]   a_mdata, b_mdata;
  logic [KW-1:0]   a_mkeep, b_mkeep;
  logic            a_mvalid, a_mready, a_mlast;
  logic            b_mvalid, b_mready, b_mlast;
  logic [IW-1:0]   a_mid, b_mid;
  logic [P*32-1:0] a_stat;
  logic [P*4-1:0]  b_stat;

  int n_total = 0;
  int n_bad   = 0;

  logic [DW-1:0] exp_q[$];
  logic          mon_en = 1'b0;
  int            mon_cnt = 0;

  int t4_bi [9] = '{0, 0, 1, 2, 2, 2, 3, -1, -1};
  int t4_mr [9] = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
  int t4_mv [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
  int t4_di [9] = '{-1, -1, 0, 1, 1, 1, 2, 3, -1};
  int t4_rd [9] = '{0, 1, 1, 0, 0, 1, 1, 0, 0};

  always #5 clk = ~clk;

  panic_rx_mux #(.AXIS_DATA_WIDTH(DW), .PORTS(P), .ARB_MODE(0), .CNT_WIDTH(32)) u_a (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(a_tdata), .s_axis_tkeep(a_tkeep), .s_axis_tvalid(a_tvalid),
    .s_axis_tready(a_tready), .s_axis_tlast(a_tlast),
    .m_axis_tdata(a_mdata), .m_axis_tkeep(a_mkeep), .m_axis_tvalid(a_mvalid),
    .m_axis_tready(a_mready), .m_axis_tlast(a_mlast), .m_axis_tid(a_mid),
    .stat_pkt_count(a_stat)
  );

  panic_rx_mux #(.AXIS_DATA_WIDTH(DW), .PORTS(P), .ARB_MODE(1), .CNT_WIDTH(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(b_tdata), .s_axis_tkeep(b_tkeep), .s_axis_tvalid(b_tvalid),
    .s_axis_tready(b_tready), .s_axis_tlast(b_tlast),
    .m_axis_tdata(b_mdata), .m_axis_tkeep(b_mkeep), .m_axis_tvalid(b_mvalid),
    .m_axis_tready(b_mready), .m_axis_tlast(b_mlast), .m_axis_tid(b_mid),
    .stat_pkt_count(b_stat)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input int p, input logic v, input logic [DW-1:0] d, input logic l);
    a_tvalid[p]        = v;
    a_tdata[p*DW +: DW] = d;
    a_tkeep[p*KW +: KW] = d[KW-1:0];
    a_tlast[p]         = l;
  endtask

  task automatic b_drive(input int p, input logic v, input logic l);
    b_tvalid[p]        = v;
    b_tdata[p*DW +: DW] = DW'(16'hF000 + p);
    b_tkeep[p*KW +: KW] = '1;
    b_tlast[p]         = l;
  endtask

  task automatic clear_inputs();
    a_tdata = '0; a_tkeep = '0; a_tvalid = '0; a_tlast = '0; a_mready = 1'b1;
    b_tdata = '0; b_tkeep = '0; b_tvalid = '0; b_tlast = '0; b_mready = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Output-side scoreboard for the stall test: each transferred beat pops one expectation.
  always @(negedge clk) begin
    if (mon_en && a_mvalid && a_mready) begin
      mon_cnt++;
      if (exp_q.size() > 0) chk("t4_beat", a_mdata, exp_q.pop_front());
    end
  end

  initial begin
    clear_inputs();
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_mvalid", a_mvalid, 0);
    chk("rst_tready", a_tready, 0);
    chk("rst_tid", a_mid, 0);
    chk("rst_stat", a_stat, 0);
    step();

    // Test 1: 3-beat packet on port 2
    a_drive(2, 1, 16'hA201, 0);
    @(negedge clk);
    chk("t1_c0_mvalid", a_mvalid, 0);
    chk("t1_c0_tready", a_tready, 0);
    step();
    @(negedge clk);
    chk("t1_c1_mvalid", a_mvalid, 0);
    chk("t1_c1_tready", a_tready, 4'b0100);
    step();
    a_drive(2, 1, 16'hA202, 0);
    @(negedge clk);
    chk("t1_b0_mvalid", a_mvalid, 1);
    chk("t1_b0_data", a_mdata, 16'hA201);
    chk("t1_b0_keep", a_mkeep, 2'b01);
    chk("t1_b0_tid", a_mid, 2);
    chk("t1_b0_last", a_mlast, 0);
    step();
    a_drive(2, 1, 16'hA203, 1);
    @(negedge clk);
    chk("t1_b1_data", a_mdata, 16'hA202);
    chk("t1_b1_keep", a_mkeep, 2'b10);
    chk("t1_b1_tid", a_mid, 2);
    step();
    a_drive(2, 0, 16'h0000, 0);
    @(negedge clk);
    chk("t1_b2_data", a_mdata, 16'hA203);
    chk("t1_b2_last", a_mlast, 1);
    chk("t1_b2_tready", a_tready, 0);
    chk("t1_stat2", a_stat[2*32 +: 32], 1);
    chk("t1_stat_other", {a_stat[3*32 +: 32], a_stat[1*32 +: 32], a_stat[0 +: 32]}, 0);
    step();
    @(negedge clk);
    chk("t1_drain_mvalid", a_mvalid, 0);
    step();

    // Test 5: reset in the middle of a 5-beat packet from port 0
    a_drive(0, 1, 16'h5500, 0);
    step();
    step();
    a_drive(0, 1, 16'h5501, 0);
    @(negedge clk);
    chk("t5_pre_mvalid", a_mvalid, 1);
    chk("t5_pre_tready", a_tready, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_mvalid", a_mvalid, 0);
    chk("t5_rst_tready", a_tready, 0);
    chk("t5_rst_data", a_mdata, 0);
    chk("t5_rst_stat", a_stat, 0);
    clear_inputs();
    step();
    rst_n = 1'b1;
    a_drive(1, 1, 16'h1100, 0);
    @(negedge clk);
    chk("t5_c0_mvalid", a_mvalid, 0);
    step();
    step();
    a_drive(1, 1, 16'h1101, 1);
    @(negedge clk);
    chk("t5_b0_mvalid", a_mvalid, 1);
    chk("t5_b0_data", a_mdata, 16'h1100);
    chk("t5_b0_tid", a_mid, 1);
    step();
    a_drive(1, 0, 16'h0000, 0);
    @(negedge clk);
    chk("t5_b1_data", a_mdata, 16'h1101);
    chk("t5_b1_last", a_mlast, 1);
    chk("t5_stat1", a_stat[1*32 +: 32], 1);
    chk("t5_stat0", a_stat[0 +: 32], 0);

    // Test 2: round-robin over four always-requesting single-beat sources
    do_reset();
    for (int p = 0; p < P; p++) a_drive(p, 1, DW'(16'h2000 + p), 1);
    for (int t = 1; t <= 16; t++) begin
      step();
      @(negedge clk);
      if (t % 2 == 0) begin
        chk("t2_mvalid", a_mvalid, 1);
        chk("t2_tid", a_mid, ((t / 2) - 1) % 4);
        chk("t2_data", a_mdata, 16'h2000 + ((t / 2) - 1) % 4);
      end else begin
        chk("t2_gap", a_mvalid, 0);
      end
    end
    for (int p = 0; p < P; p++) chk("t2_stat", a_stat[p*32 +: 32], 2);

    // Test 4: downstream stalls during a 4-beat packet from port 0
    do_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(DW'(16'hB0C0 + i));
    mon_en = 1'b1;
    for (int t = 0; t < 9; t++) begin
      if (t > 0) step();
      if (t4_bi[t] >= 0) a_drive(0, 1, DW'(16'hB0C0 + t4_bi[t]), t4_bi[t] == 3);
      else a_drive(0, 0, 16'h0000, 0);
      a_mready = t4_mr[t][0];
      @(negedge clk);
      chk("t4_mvalid", a_mvalid, t4_mv[t]);
      chk("t4_tready0", a_tready[0], t4_rd[t]);
      if (t4_di[t] >= 0) begin
        chk("t4_hold_data", a_mdata, 16'hB0C0 + t4_di[t]);
        chk("t4_hold_last", a_mlast, t4_di[t] == 3);
      end
    end
    mon_en = 1'b0;
    chk("t4_beat_count", mon_cnt, 4);
    chk("t4_queue_left", exp_q.size(), 0);

    // Test 3: fixed priority with ports 1 and 3 always requesting
    do_reset();
    b_drive(1, 1, 1);
    b_drive(3, 1, 1);
    for (int t = 1; t <= 10; t++) begin
      step();
      @(negedge clk);
      chk("t3_tready3", b_tready[3], 0);
      chk("t3_mvalid", b_mvalid, t % 2 == 0);
      if (t % 2 == 0) chk("t3_tid", b_mid, 1);
    end
    chk("t3_stat1", b_stat[1*4 +: 4], 5);
    chk("t3_stat3", b_stat[3*4 +: 4], 0);

    // Test 6: 4-bit packet counter wraps after 16 packets
    do_reset();
    b_drive(0, 1, 1);
    for (int t = 1; t <= 34; t++) begin
      step();
      @(negedge clk);
      if (t == 30) chk("t6_stat15", b_stat[0 +: 4], 15);
      if (t == 32) chk("t6_stat_wrap", b_stat[0 +: 4], 0);
    end
    chk("t6_stat17", b_stat[0 +: 4], 1);
    b_drive(0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
